imm_ext_pipe: RTL and testbench

//  Pipelined, parametrised immediate/offset extractor for the datapath decode stage.
//  - Takes an instruction word and a field-select mode.
//  - Extracts imm5 / offset6 / PCoffset9 / PCoffset11 / trapvect8 from the word's LSBs.
//  - Sign- or zero-extends the field to WORD_W bits.
//  - Optionally adds the result to a base register.
//  - Two registered stages with valid/ready flow control between the decode and address units.

---
 rtl/imm_ext_pkg.sv | 23 ++
 rtl/imm_ext_pipe_field_ext.sv | 32 +++
 rtl/imm_ext_pipe.sv | 104 ++++++++++
 tb/tb_imm_ext_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types and field widths for the pipelined immediate/offset extractor.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    IMM5  = 3'd0,
    OFF6  = 3'd1,
    OFF9  = 3'd2,
    OFF11 = 3'd3,
    TRAP8 = 3'd4
  } imm_mode_e;

  localparam int W_IMM5  = 5;
  localparam int W_OFF6  = 6;
  localparam int W_OFF9  = 9;
  localparam int W_OFF11 = 11;
  localparam int W_TRAP8 = 8;

  // Encodings 5..7 have no field behind them.
  function automatic logic is_legal_mode(input logic [2:0] m);
    return (m <= 3'(TRAP8));
  endfunction

endpackage

// File: rtl/imm_ext_pipe_field_ext.sv
// Combinational field extractor: picks the immediate selected by mode out of IR
// and sign- or zero-extends it to WORD_W bits; illegal modes yield 0.
module field_ext
  import imm_ext_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] IR,
  input  logic [2:0]        mode,
  output logic [WORD_W-1:0] ext,
  output logic              illegal
);

  // Bits above the widest field never feed the result.
  logic unused_ir_hi;
  assign unused_ir_hi = ^IR[WORD_W-1:W_OFF11];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ext     = '0;
    illegal = !is_legal_mode(mode);
    case (imm_mode_e'(mode))
      IMM5:    ext = {{(WORD_W-W_IMM5){IR[W_IMM5-1]}},   IR[W_IMM5-1:0]};
      OFF6:    ext = {{(WORD_W-W_OFF6){IR[W_OFF6-1]}},   IR[W_OFF6-1:0]};
      OFF9:    ext = {{(WORD_W-W_OFF9){IR[W_OFF9-1]}},   IR[W_OFF9-1:0]};
      OFF11:   ext = {{(WORD_W-W_OFF11){IR[W_OFF11-1]}}, IR[W_OFF11-1:0]};
      TRAP8:   ext = {{(WORD_W-W_TRAP8){1'b0}},          IR[W_TRAP8-1:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate extractor with optional base+offset adder.
// Define IMM_ADDR_ADD_EN to build the adder; otherwise addr_out is tied to 0.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    IR,
  input  logic [2:0]           mode,
  input  logic [WORD_W-1:0]    base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    ext_out,
  output logic [WORD_W-1:0]    addr_out,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 s1_v, s2_v;
  logic [WORD_W-1:0]    ir_s1;
  logic [2:0]           mode_s1;
  logic [WORD_W-1:0]    ext_s1;
  logic                 illegal_s1;
  logic [WORD_W-1:0]    ext_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 s1_ready, s2_ready;
  logic                 in_fire, s1_adv, out_fire;

  assign s2_ready = !s2_v || out_ready;
  assign s1_ready = !s1_v || s2_ready;
  // Held low while Reset is asserted so nothing is offered as accepted during reset.
  assign in_ready = s1_ready && !Reset;
  assign in_fire  = in_valid && s1_ready;
  assign s1_adv   = s1_v && s2_ready;
  assign out_fire = s2_v && out_ready;

  field_ext #(.WORD_W(WORD_W)) u_field_ext (
    .IR      (ir_s1),
    .mode    (mode_s1),
    .ext     (ext_s1),
    .illegal (illegal_s1)
  );

  // NOTE: S1 payload needs no reset; s1_v qualifies it and reset clears s1_v.
  always_ff @(posedge Clk) begin
    if (in_fire) begin
      ir_s1   <= IR;
      mode_s1 <= mode;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (Reset) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      ext_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (s1_ready) s1_v <= in_valid;
      if (s2_ready) s2_v <= s1_v;
      if (s1_adv) begin
        ext_q <= ext_s1;
        err_q <= illegal_s1;
      end
      if (out_fire && err_q && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

`ifdef IMM_ADDR_ADD_EN
  logic [WORD_W-1:0] base_s1;
  logic [WORD_W-1:0] addr_q;

  always_ff @(posedge Clk) begin
    if (in_fire) base_s1 <= base;
  end

  // Illegal modes pass the base through untouched; the add wraps modulo 2^WORD_W.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       addr_q <= '0;
    else if (s1_adv) addr_q <= illegal_s1 ? base_s1 : base_s1 + ext_s1;
  end

  assign addr_out = addr_q;
`else
  logic unused_base;
  assign unused_base = ^base;
  assign addr_out    = '0;
`endif

  assign out_valid = s2_v;
  assign ext_out   = ext_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (default and IMM_ADDR_ADD_EN builds).
module tb_imm_ext_pipe;
  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] IR = '0;
  logic [2:0]   mode = '0;
  logic [W-1:0] base = '0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid, err;
  logic [W-1:0] ext_out, addr_out;
  logic [7:0]   err_cnt;

  logic         in_ready2, out_valid2, err2;
  logic [W-1:0] ext_out2, addr_out2;
  logic [1:0]   err_cnt2;

  int total = 0;
  int bad   = 0;

  imm_ext_pipe #(.WORD_W(W), .ERR_CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .IR(IR), .mode(mode), .base(base), .out_valid(out_valid), .out_ready(out_ready),
    .ext_out(ext_out), .addr_out(addr_out), .err(err), .err_cnt(err_cnt)
  );

  imm_ext_pipe #(.WORD_W(W), .ERR_CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready2),
    .IR(IR), .mode(mode), .base(base), .out_valid(out_valid2), .out_ready(out_ready),
    .ext_out(ext_out2), .addr_out(addr_out2), .err(err2), .err_cnt(err_cnt2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_addr(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic ill);
`ifdef IMM_ADDR_ADD_EN
    return ill ? b : W'(b + e);
`else
    return '0;
`endif
  endfunction

  // Called one time unit after a rising edge with an empty pipe and out_ready=1.
  task automatic single(input string tag, input logic [W-1:0] ir_v, input logic [2:0] m,
                        input logic [W-1:0] b, input logic [W-1:0] e, input logic ill);
    IR = ir_v; mode = m; base = b; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, ".ext"},   64'(ext_out),   64'(e));
    check({tag, ".err"},   64'(err),       64'(ill));
    check({tag, ".addr"},  64'(addr_out),  64'(exp_addr(b, e, ill)));
  endtask

  initial begin
    int accepts, received, idx;
    logic fire_in, fire_out, stale;

    // Reset and idle
    #1 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.in_ready",  64'(in_ready),  64'(0));
    check("rst.ext",       64'(ext_out),   64'(0));
    check("rst.addr",      64'(addr_out),  64'(0));
    check("rst.err_cnt",   64'(err_cnt),   64'(0));
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("idle.in_ready",  64'(in_ready),  64'(1));
    check("idle.out_valid", 64'(out_valid), 64'(0));

    // Field extraction
    single("imm5_neg",  16'h001F, 3'd0, 16'h0000, 16'hFFFF, 1'b0);
    single("imm5_hi",   16'hFFE0, 3'd0, 16'h0000, 16'h0000, 1'b0);
    single("off6_neg",  16'h0020, 3'd1, 16'h0000, 16'hFFE0, 1'b0);
    single("off9_neg",  16'h01FF, 3'd2, 16'h0000, 16'hFFFF, 1'b0);
    single("off11_pos", 16'h03FF, 3'd3, 16'h0000, 16'h03FF, 1'b0);
    single("trap8",     16'h00FF, 3'd4, 16'h0000, 16'h00FF, 1'b0);

    // Address add (0 when the adder is compiled out)
    single("add_off9",  16'h01F0, 3'd2, 16'h3000, 16'hFFF0, 1'b0);
    single("add_wrap",  16'h0001, 3'd0, 16'hFFFF, 16'h0001, 1'b0);

    // Illegal modes
    single("ill_a", 16'h1234, 3'd5, 16'h4000, 16'h0000, 1'b1);
    single("ill_b", 16'h00FF, 3'd6, 16'h4001, 16'h0000, 1'b1);
    single("ill_c", 16'hFFFF, 3'd7, 16'h4002, 16'h0000, 1'b1);
    @(posedge Clk); #1;
    check("errcnt3",   64'(err_cnt),  64'(3));
    check("errcnt3_w2", 64'(err_cnt2), 64'(3));
    single("ill_d", 16'h0000, 3'd5, 16'h0000, 16'h0000, 1'b1);
    single("ill_e", 16'h0000, 3'd5, 16'h0000, 16'h0000, 1'b1);
    @(posedge Clk); #1;
    check("errcnt5",     64'(err_cnt),  64'(5));
    check("errcnt_sat2", 64'(err_cnt2), 64'(3));

    // Backpressure: 5 stalled cycles, then drain 6 TRAP8 items in order
    accepts = 0; received = 0; idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin
        check("bp.accepts",  64'(accepts),  64'(2));
        check("bp.in_ready", 64'(in_ready), 64'(0));
      end
      out_ready = (c >= 5);
      in_valid  = (idx < 6);
      IR        = W'(16'h0010 + idx);
      mode      = 3'd4;
      base      = '0;
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        check("bp.order", 64'(ext_out), 64'(16'h0010 + received));
        received++;
      end
      @(posedge Clk); #1;
      if (fire_in) begin
        idx++;
        if (c < 5) accepts++;
      end
      if (idx == 6 && received == 6) break;
    end
    in_valid = 1'b0;
    check("bp.received", 64'(received), 64'(6));
    @(posedge Clk); #1;
    check("bp.drained", 64'(out_valid), 64'(0));

    // Reset with both stages full
    out_ready = 1'b0;
    IR = 16'h001F; mode = 3'd0; in_valid = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    in_valid = 1'b0;
    check("mid.full", 64'(out_valid), 64'(1));
    Reset = 1'b1;
    #1;
    check("mid.out_valid", 64'(out_valid), 64'(0));
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("mid.no_stale", 64'(stale),   64'(0));
    check("mid.err_cnt",  64'(err_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
